// File: rtl/io_bridge.sv
// io_bridge: external-side partner of the processor's 16-bit I/O ports.
// Output path: every change on ioOutput is captured into a small FIFO and
// offered downstream. Input path: accepted words are held on ioInput and
// further input is refused for HOLD_CYCLES cycles so the CPU has time to
// see each one.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready in the same cycle. out_valid and
// in_ready are decoded from or held in registers only.
module io_bridge #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [15:0]              ioOutput,
  output logic [15:0]              ioInput,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  // ---------------------------------------------------------------------
  // Output path: change detect + circular FIFO
  // ---------------------------------------------------------------------
  logic [15:0]      prevQ;
  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             pushReq;
  logic             popFire;
  logic             fifoFull;
  logic             pushOk;

  // Push/pop decode. When full, a same-edge pop frees the slot being written,
  // so the write lands on the head entry while that entry is being consumed.
  always_comb begin
    pushReq   = (ioOutput != prevQ);
    out_valid = (fifo_count != '0);
    popFire   = out_valid && out_ready;
    fifoFull  = (fifo_count == CNT_W'(DEPTH));
    pushOk    = pushReq && (!fifoFull || popFire);
    out_data  = out_valid ? mem[rdPtr] : 16'h0000;
  end

  // Storage array; not reset, entries are only visible through out_valid.
  always_ff @(posedge CLK) begin
    if (!reset && pushOk) begin
      mem[wrPtr] <= ioOutput;
    end
  end

  // Previous-value register, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      prevQ      <= 16'h0000;
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      prevQ <= ioOutput;
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case ({pushOk, popFire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (pushReq && !pushOk) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Input path: READY/HOLD FSM
  // ---------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_HOLD  = 1'b1
  } inState_t;

  inState_t          inState;
  logic [HOLD_W-1:0] holdCnt;

  // Accept a word when ready, then refuse input for HOLD_CYCLES cycles.
  // in_ready is a register kept in step with the state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      inState  <= ST_READY;
      holdCnt  <= '0;
      ioInput  <= 16'h0000;
      in_ready <= 1'b1;
    end else begin
      unique case (inState)
        ST_READY: begin
          if (in_valid) begin
            ioInput <= in_data;
            if (HOLD_CYCLES > 0) begin
              holdCnt  <= HOLD_W'(HOLD_CYCLES);
              inState  <= ST_HOLD;
              in_ready <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          holdCnt <= holdCnt - 1'b1;
          if (holdCnt == HOLD_W'(1)) begin
            inState  <= ST_READY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          inState  <= ST_READY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Testbench for io_bridge: directed scenarios followed by a randomized phase,
// all checked against a queue-based reference model of the bridge.
module tb_io_bridge;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             reset;
  logic [15:0]      ioOutput;
  logic [15:0]      ioInput;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  io_bridge #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .ioOutput   (ioOutput),
    .ioInput    (ioInput),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  logic [15:0] m_prev;
  bit          m_ovf;
  logic [15:0] m_in;
  int          m_busy;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present before the edge.
  task automatic model_edge();
    bit pop;
    bit push;
    if (reset) begin
      exp_q.delete();
      m_prev = 16'h0000;
      m_ovf  = 1'b0;
      m_in   = 16'h0000;
      m_busy = 0;
    end else begin
      pop  = (exp_q.size() > 0) && out_ready;
      push = (ioOutput != m_prev);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ioOutput);
        else m_ovf = 1'b1;
      end
      m_prev = ioOutput;
      if (m_busy > 0) m_busy--;
      else if (in_valid) begin
        m_in   = in_data;
        m_busy = HOLD;
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
    check("out_valid",  32'(out_valid),  32'(exp_q.size() > 0));
    check("out_data",   32'(out_data),   32'(head));
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("ioInput",    32'(ioInput),    32'(m_in));
    check("in_ready",   32'(in_ready),   32'(m_busy == 0));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int abcd_cycles;
  int low_cycles;
  bit hit_1234;

  initial begin
    reset     = 1'b1;
    ioOutput  = 16'h0000;
    out_ready = 1'b0;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    m_prev = 0; m_ovf = 0; m_in = 0; m_busy = 0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    // Release with ioOutput = 0 -> no capture
    step();
    check("no_capture", 32'(fifo_count), 32'd0);

    // Capture and drain: 1,2,2,3
    ioOutput = 16'h0001; step();
    ioOutput = 16'h0002; step();
    ioOutput = 16'h0002; step();
    ioOutput = 16'h0003; step();
    check("capture_count", 32'(fifo_count), 32'd3);
    check("drain_head0", 32'(out_data), 32'h1);
    out_ready = 1'b1;
    step(); check("drain_head1", 32'(out_data), 32'h2);
    step(); check("drain_head2", 32'(out_data), 32'h3);
    step(); check("drain_empty", 32'(out_valid), 32'd0);

    // Overflow: 5 distinct changes with out_ready low
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ioOutput = 16'(16'h0010 + i);
      step();
    end
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag",  32'(overflow),   32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioOutput = 16'(16'h0021 + i);
      step();
    end
    out_ready = 1'b1;
    ioOutput  = 16'h0025;
    step();
    check("fullpp_count", 32'(fifo_count), 32'd4);
    check("fullpp_ovf",   32'(overflow),   32'd0);
    for (int i = 0; i < 3; i++) step();
    check("fullpp_last", 32'(out_data), 32'h25);
    step();

    // Input hold: ABCD then 1234 with in_valid held
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    step();
    in_data  = 16'h1234;
    abcd_cycles = 0;
    low_cycles  = 0;
    hit_1234    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ioInput == 16'h1234) begin
        hit_1234 = 1'b1;
        break;
      end
      if (ioInput == 16'hABCD) abcd_cycles++;
      if (!in_ready) low_cycles++;
      step();
    end
    check("hold_reached", 32'(hit_1234),  32'd1);
    check("hold_abcd",    32'(abcd_cycles), 32'd9);
    check("hold_low",     32'(low_cycles),  32'd8);
    in_valid = 1'b0;
    step();

    // Wrap-around: 3*DEPTH+1 distinct words with out_ready high
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      ioOutput = 16'(16'h0100 + i);
      step();
      check("wrap_bound", 32'(fifo_count <= CNT_W'(DEPTH)), 32'd1);
    end
    for (int i = 0; i < DEPTH + 1; i++) step();

    // Randomized traffic with occasional mid-activity reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) ioOutput = 16'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      reset     = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;

    // Reset while active
    ioOutput  = 16'h0055;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("midrst_count",   32'(fifo_count), 32'd0);
    check("midrst_ioInput", 32'(ioInput),    32'd0);
    check("midrst_ready",   32'(in_ready),   32'd1);
    check("midrst_ovf",     32'(overflow),   32'd0);
    check("midrst_data",    32'(out_data),   32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst_capture", 32'(fifo_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
